// File: rtl/rom_loader_pkg.sv
// Shared widths, default load length and FSM state encoding for rom_loader.
package rom_loader_pkg;

    localparam int DEF_DATA_W   = 10;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_LOAD_LEN = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rom_loader_array.sv
// 2**ADDR_W x DATA_W register file: async clear, one write port, combinational read.
module rom_loader_array
    import rom_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the old word until the write edge lands.
    assign rdata = mem[raddr];

endmodule

// File: rtl/rom_loader.sv
// Run-time loadable replacement for the fixed Rom table: valid/ready writer plus
// combinational read port. Define ROM_LOADER_CHECKSUM_EN to add an XOR checksum output.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LOAD_LEN = DEF_LOAD_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(LOAD_LEN - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              xfer;

    assign xfer = wr_valid && wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            wr_count <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        wr_ptr   <= '0;
                        wr_count <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        wr_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        wr_count <= wr_count + 1'b1;
                        // Final word: wr_ready falls next cycle so DONE blocks any wrap write.
                        if (wr_count == LAST_CNT) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            wr_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (state != ST_LOAD && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum ^ wr_data;
        end
    end
`endif

    rom_loader_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (xfer),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(addr),
        .rdata(data)
    );

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: accepted words are queued and checked on readback.
module tb_rom_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       wr_valid = 1'b0;
    logic [9:0] wr_data = '0;
    logic       wr_ready;
    logic [3:0] addr = '0;
    logic [9:0] data;
    logic       busy;
    logic       done;
    logic [4:0] wr_count;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [9:0] checksum;
`endif

    int total = 0;
    int bad = 0;

    logic [9:0] sb[$];
    logic [9:0] model[16];
    logic [9:0] words[10];
    int ready_cyc, busy_cyc;

    always #5 clk = ~clk;

    rom_loader dut (
        .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .addr(addr), .data(data), .busy(busy), .done(done),
        .wr_count(wr_count)
`ifdef ROM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic check_flags(input string name, input logic b, input logic d, input logic r,
                               input logic [4:0] c);
        total++;
        if ({busy, done, wr_ready, wr_count} !== {b, d, r, c}) begin
            bad++;
            $display("FAIL %s: busy/done/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                     name, busy, done, wr_ready, wr_count, b, d, r, c);
        end
    endtask

    task automatic sweep(input string name);
        logic [9:0] exp;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            if (sb.size() > 0) exp = sb.pop_front();
            else exp = model[a];
            total++;
            if (data !== exp) begin
                bad++;
                $display("FAIL %s addr %0d: data got %h want %h", name, a, data, exp);
            end
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs from a negedge in LOAD until n words are accepted; stall inserts idle cycles.
    task automatic load(input int n, input bit stall, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit phase = 1'b1;
        ready_cyc = 0;
        busy_cyc = 0;
        while (idx < n && cyc < 200) begin
            if (wr_ready) ready_cyc++;
            if (busy) busy_cyc++;
            total++;
            if (wr_count !== 5'(idx)) begin
                bad++;
                $display("FAIL wr_count_track: got %0d want %0d", wr_count, idx);
            end
            wr_valid = stall ? phase : 1'b1;
            phase = ~phase;
            wr_data = words[idx];
            start = (idx == start_at);
            addr = 4'(idx);
            #1;
            if (wr_valid && wr_ready) begin
                total++;
                if (data !== model[idx]) begin
                    bad++;
                    $display("FAIL read_before_write addr %0d: got %h want %h", idx, data, model[idx]);
                end
                sb.push_back(words[idx]);
                model[idx] = words[idx];
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        start = 1'b0;
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL load_timeout: accepted %0d want %0d", idx, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_flags("reset_in", 1'b0, 1'b0, 1'b0, 5'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) model[i] = '0;
        sb.delete();
        check_flags("idle", 1'b0, 1'b0, 1'b0, 5'd0);
        sweep("reset_sweep");
    endtask

    task automatic test_basic;
        words[0] = 10'h3FF;
        for (int i = 1; i < 10; i++) words[i] = 10'(i);
        pulse_start();
        load(10, 1'b0, -1);
        total++;
        if (ready_cyc != 10) begin
            bad++;
            $display("FAIL basic_ready_cycles: got %0d want 10", ready_cyc);
        end
        check_flags("basic_done", 1'b0, 1'b1, 1'b0, 5'd10);
        sweep("basic_sweep");
    endtask

    task automatic test_stalls;
        pulse_start();
        load(10, 1'b1, -1);
        total++;
        if (busy_cyc != 19) begin
            bad++;
            $display("FAIL stall_busy_cycles: got %0d want 19", busy_cyc);
        end
        check_flags("stall_done", 1'b0, 1'b1, 1'b0, 5'd10);
        sweep("stall_sweep");
    endtask

    task automatic test_ignored_start;
        for (int i = 0; i < 10; i++) words[i] = 10'h100 + 10'(i);
        pulse_start();
        check_flags("restart_done_clear", 1'b1, 1'b0, 1'b1, 5'd0);
        load(10, 1'b0, 4);
        check_flags("midstart_done", 1'b0, 1'b1, 1'b0, 5'd10);
        sweep("midstart_sweep");
        for (int i = 0; i < 10; i++) words[i] = 10'h2AA;
        pulse_start();
        check_flags("second_start", 1'b1, 1'b0, 1'b1, 5'd0);
        load(10, 1'b0, -1);
        check_flags("second_done", 1'b0, 1'b1, 1'b0, 5'd10);
        sweep("second_sweep");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 10; i++) words[i] = 10'h055 + 10'(3 * i);
        pulse_start();
        load(5, 1'b0, -1);
        check_flags("pre_abort", 1'b1, 1'b0, 1'b1, 5'd5);
        #2 rst = 1'b1;
        #1;
        check_flags("async_abort", 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        sweep("abort_sweep");
        pulse_start();
        load(10, 1'b0, -1);
        check_flags("reload_done", 1'b0, 1'b1, 1'b0, 5'd10);
        sweep("reload_sweep");
    endtask

`ifdef ROM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        logic [9:0] exp = '0;
        for (int i = 0; i < 10; i++) begin
            words[i] = 10'(i + 1);
            exp ^= words[i];
        end
        pulse_start();
        load(10, 1'b0, -1);
        total++;
        if (checksum !== exp) begin
            bad++;
            $display("FAIL checksum_done: got %h want %h", checksum, exp);
        end
        sweep("checksum_sweep");
        pulse_start();
        total++;
        if (checksum !== 10'h000) begin
            bad++;
            $display("FAIL checksum_clear: got %h want 000", checksum);
        end
        load(10, 1'b0, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_ignored_start();
        test_reset_mid();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
